spatz_vfu_pipe: RTL and testbench
=================================

Name: spatz_vfu_pipe

Overview:
- Parametrised successor to the single-cycle Spatz VFU.
- Executes element-wise integer vector ops (add, sub, and, or, xor) over NrIPUs 32-bit lanes, with a configurable result pipeline of Latency stages.
- Each in-flight word carries its own write-back context, so the next instruction is accepted as soon as the current one has issued its last word.
- Sits between the Spatz controller (request/response) and the VRF (3 read ports, 1 write port).

Parameters:
- NrIPUs, 4, number of 32-bit lanes; VRF word = NrIPUs*32 bits.
- Latency, 2, number of registered stages between operand fetch and VRF write; legal range 1..8.
- NrWordsPerVector, 8, VRF words per architectural vector register.
- VlW, 16, width of vl/vstart.
- IdW, 3, instruction id width.
- AddrW, $clog2(32*NrWordsPerVector), VRF word address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with valid.
- req_id_i  in  IdW  instruction id.
- req_op_i  in  3  0 ADD, 1 SUB (vs2-vs1), 2 AND, 3 OR, 4 XOR; 5-7 reserved, result 0.
- req_sew_i  in  2  0 = 8 bit, 1 = 16 bit, 2 = 32 bit; 3 is illegal and treated as 32 bit.
- req_vl_i, req_vstart_i  in  VlW  vector length, start element.
- req_vs1_i, req_vs2_i, req_vd_i  in  5  register numbers.
- req_use_vs1_i, req_use_vd_i  in  1  vs1 is a vector (else scalar); write vd.
- req_rs1_i  in  32  scalar operand, replicated per element width.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_id_o  out  IdW  id of the completed instruction.
- vrf_raddr_o  out  2*AddrW  read addresses [0]=vs2, [1]=vs1.
- vrf_re_o  out  2  read enables.
- vrf_rdata_i  in  2*NrIPUs*32  read data.
- vrf_rvalid_i  in  2  read data valid, same cycle as data.
- vrf_waddr_o  out  AddrW  write address.
- vrf_wdata_o  out  NrIPUs*32  write data.
- vrf_we_o  out  1  write enable.
- vrf_wbe_o  out  NrIPUs*4  byte enables.
- vrf_wvalid_i  in  1  write accepted.

Behaviour:
- Reset: all outputs 0; issue stage idle; all pipeline stages invalid.
- epw (elements per word) = NrIPUs*4 >> sew.
- Word range: first = vstart/epw, last = (vl-1)/epw; addresses = {reg, 3'b0} + word index.
- Issue FSM states:
  - IDLE: req_ready_o = 1. On accept, latch the request and go to ISSUE. If vl==0 or vstart>=vl, go to TOKEN instead.
  - ISSUE: vrf_re_o = {use_vs1, 1}. A word fires when all enabled rvalid are high AND stage 0 can load. On fire, increment the word index. When the last word fires, req_ready_o is high in that same cycle and a new request may be accepted (back-to-back, no bubble).
  - TOKEN: injects one write-less entry carrying last=1 into stage 0, then returns to IDLE. req_ready_o behaves as in ISSUE.
- Pipeline advance: the whole pipe advances when the output stage is invalid OR (vrf_wvalid_i OR !we). Otherwise every stage holds. There are no bubbles-collapse requirements.
- Each stage carries: valid, we, addr, be, last, id, result.
- Result computation:
  - Lane ops are computed per element width with no carry across element boundaries.
  - Scalar operand replicated: rs1[7:0] ×4 per lane for 8 bit, rs1[15:0] ×2 per lane for 16 bit.
  - Reserved ops produce 0.
- Byte enable:
  - Default all ones.
  - First word: clear bytes below (vstart mod epw) << sew.
  - Last word: clear bytes at or above (((vl-1) mod epw)+1) << sew.
  - If first word == last word, AND both masks.
- Output stage: vrf_we_o = valid & we; addr, be and data come from the stage.
- Response: rsp_valid_o pulses, with the entry's id, in the cycle an entry with last=1 leaves the output stage (write accepted, or we=0). Responses are in issue order; at most one per cycle.
- Latency: a fired word is presented on the write port Latency cycles later when unstalled.
- vrf_wvalid_i low holds the output stage and write signals stable until accepted.
- Reset mid-operation: all in-flight words are discarded, no response is emitted, and the FSM returns to IDLE.

Test Plan:
- NrIPUs=4, Latency=2, sew=32, vl=8, vstart=0, ADD vs1=1 vs2=2 vd=3 -> writes at addr 24 then 25, be=0xFFFF each; first write 2 cycles after fire; rsp_valid one cycle-pulse with id.
- sew=8, vl=21, vstart=3, SUB with scalar rs1=0x01 -> word0 be=0xFFF8, word1 be=0x001F; each byte = vs2-1, 0x00-1 = 0xFF with no borrow into the neighbouring byte.
- Back-to-back: two 1-word requests on consecutive cycles, rvalid always high -> writes in consecutive cycles, rsp ids in order, req_ready_o never deasserts.
- vrf_wvalid_i held low 5 cycles mid-stream -> write signals stable, no reads fire once stage 0 is full, no word lost or duplicated.
- vl=0 request between two normal requests -> no VRF write for it; its rsp_valid falls between the other two responses.
- Assert rst_ni during ISSUE with 2 words in flight -> all outputs 0 asynchronously; no rsp after release; next request executes normally.

Source files
------------

// File: rtl/spatz_vfu_pipe.sv
// Pipelined Spatz vector functional unit: element-wise integer ops over NrIPUs
// 32-bit lanes, Latency result stages, per-word write-back context.
module spatz_vfu_pipe #(
  parameter int unsigned NrIPUs           = 4,
  parameter int unsigned Latency          = 2,
  parameter int unsigned NrWordsPerVector = 8,
  parameter int unsigned VlW              = 16,
  parameter int unsigned IdW              = 3,
  parameter int unsigned AddrW            = $clog2(32*NrWordsPerVector)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IdW-1:0]          req_id_i,
  input  logic [2:0]              req_op_i,
  input  logic [1:0]              req_sew_i,
  input  logic [VlW-1:0]          req_vl_i,
  input  logic [VlW-1:0]          req_vstart_i,
  input  logic [4:0]              req_vs1_i,
  input  logic [4:0]              req_vs2_i,
  input  logic [4:0]              req_vd_i,
  input  logic                    req_use_vs1_i,
  input  logic                    req_use_vd_i,
  input  logic [31:0]             req_rs1_i,
  output logic                    rsp_valid_o,
  output logic [IdW-1:0]          rsp_id_o,
  output logic [2*AddrW-1:0]      vrf_raddr_o,
  output logic [1:0]              vrf_re_o,
  input  logic [2*NrIPUs*32-1:0]  vrf_rdata_i,
  input  logic [1:0]              vrf_rvalid_i,
  output logic [AddrW-1:0]        vrf_waddr_o,
  output logic [NrIPUs*32-1:0]    vrf_wdata_o,
  output logic                    vrf_we_o,
  output logic [NrIPUs*4-1:0]     vrf_wbe_o,
  input  logic                    vrf_wvalid_i
);

  localparam int unsigned WordW    = NrIPUs*32;
  localparam int unsigned NrBytes  = NrIPUs*4;
  localparam int unsigned WordOffW = $clog2(NrBytes);
  localparam int unsigned ByteIdxW = WordOffW + 1;

  typedef enum logic [1:0] {Idle, Issue, Token} state_e;

  // Element-width-aware lane ALU; carries never cross element boundaries.
  function automatic logic [31:0] lane_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic [1:0] sew);
    logic [31:0] add8, sub8, add16, sub16, r;
    for (int k = 0; k < 4; k++) begin
      add8[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
      sub8[8*k +: 8] = a[8*k +: 8] - b[8*k +: 8];
    end
    for (int k = 0; k < 2; k++) begin
      add16[16*k +: 16] = a[16*k +: 16] + b[16*k +: 16];
      sub16[16*k +: 16] = a[16*k +: 16] - b[16*k +: 16];
    end
    case (op)
      3'd0:    r = (sew == 2'd0) ? add8 : (sew == 2'd1) ? add16 : a + b;
      3'd1:    r = (sew == 2'd0) ? sub8 : (sew == 2'd1) ? sub16 : a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e               state_q;
  logic                 init_q;
  logic [VlW-1:0]       word_q, first_q, last_q;
  logic [IdW-1:0]       id_q;
  logic [2:0]           op_q;
  logic [1:0]           sew_q;
  logic [4:0]           vs1_q, vs2_q, vd_q;
  logic                 use_vs1_q, use_vd_q;
  logic [31:0]          rs1_q;
  logic [ByteIdxW-1:0]  lo_q, hi_q;

  logic [Latency-1:0]   vld_q, we_q, last_stg_q;
  logic [IdW-1:0]       id_stg_q   [Latency];
  logic [AddrW-1:0]     addr_stg_q [Latency];
  logic [NrBytes-1:0]   be_stg_q   [Latency];
  logic [WordW-1:0]     res_stg_q  [Latency];

  // Request decode: word range and partial-word byte bounds.
  logic [1:0]           sew_d;
  logic [4:0]           eshift_d;
  logic [VlW-1:0]       emask_d, vl_m1_d, first_d, last_d;
  logic [ByteIdxW-1:0]  lo_d, hi_d;
  logic                 empty_d;

  assign sew_d    = (req_sew_i == 2'd3) ? 2'd2 : req_sew_i;
  assign eshift_d = 5'(WordOffW) - 5'(sew_d);
  assign emask_d  = (VlW'(1) << eshift_d) - VlW'(1);
  assign vl_m1_d  = req_vl_i - VlW'(1);
  assign first_d  = req_vstart_i >> eshift_d;
  assign last_d   = vl_m1_d >> eshift_d;
  assign lo_d     = ByteIdxW'((req_vstart_i & emask_d) << sew_d);
  assign hi_d     = ByteIdxW'(((vl_m1_d & emask_d) + VlW'(1)) << sew_d);
  assign empty_d  = (req_vl_i == '0) || (req_vstart_i >= req_vl_i);

  logic adv, rd_ok, fire, tok, is_last, accept;

  assign adv     = !vld_q[Latency-1] || !we_q[Latency-1] || vrf_wvalid_i;
  assign rd_ok   = vrf_rvalid_i[0] && (!use_vs1_q || vrf_rvalid_i[1]);
  assign fire    = (state_q == Issue) && rd_ok && adv;
  assign tok     = (state_q == Token) && adv;
  assign is_last = (word_q == last_q);
  assign req_ready_o = init_q && ((state_q == Idle) || (fire && is_last) || tok);
  assign accept  = req_valid_i && req_ready_o;

  logic [AddrW-1:0] vs1_addr, vs2_addr, vd_addr;
  assign vs1_addr = AddrW'(AddrW'(vs1_q) * AddrW'(NrWordsPerVector)) + AddrW'(word_q);
  assign vs2_addr = AddrW'(AddrW'(vs2_q) * AddrW'(NrWordsPerVector)) + AddrW'(word_q);
  assign vd_addr  = AddrW'(AddrW'(vd_q) * AddrW'(NrWordsPerVector)) + AddrW'(word_q);

  assign vrf_re_o    = (state_q == Issue) ? {use_vs1_q, 1'b1} : 2'b00;
  assign vrf_raddr_o = (state_q == Issue) ? {vs1_addr, vs2_addr} : '0;

  logic [31:0]        scalar_rep;
  logic [WordW-1:0]   res_d;
  logic [NrBytes-1:0] be_d;

  always_comb begin
    case (sew_q)
      2'd0:    scalar_rep = {4{rs1_q[7:0]}};
      2'd1:    scalar_rep = {2{rs1_q[15:0]}};
      default: scalar_rep = rs1_q;
    endcase
    res_d = '0;
    for (int l = 0; l < NrIPUs; l++) begin
      res_d[32*l +: 32] = lane_alu(vrf_rdata_i[32*l +: 32],
                                   use_vs1_q ? vrf_rdata_i[WordW + 32*l +: 32] : scalar_rep,
                                   op_q, sew_q);
    end
    be_d = '1;
    for (int b = 0; b < NrBytes; b++) begin
      if ((word_q == first_q) && (ByteIdxW'(b) < lo_q)) be_d[b] = 1'b0;
      if ((word_q == last_q) && (ByteIdxW'(b) >= hi_q)) be_d[b] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      init_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        state_q <= empty_d ? Token : Issue;
        word_q  <= first_d;
      end else if (fire && is_last) begin
        state_q <= Idle;
      end else if (fire) begin
        word_q <= word_q + VlW'(1);
      end else if (tok) begin
        state_q <= Idle;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_q      <= req_id_i;
      op_q      <= req_op_i;
      sew_q     <= sew_d;
      vs1_q     <= req_vs1_i;
      vs2_q     <= req_vs2_i;
      vd_q      <= req_vd_i;
      use_vs1_q <= req_use_vs1_i;
      use_vd_q  <= req_use_vd_i;
      rs1_q     <= req_rs1_i;
      first_q   <= first_d;
      last_q    <= last_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  // ---- stage 0 .. Latency-1: the whole pipe moves or holds as one ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      we_q       <= '0;
      last_stg_q <= '0;
      for (int i = 0; i < Latency; i++) id_stg_q[i] <= '0;
    end else if (adv) begin
      vld_q[0]      <= fire || tok;
      we_q[0]       <= fire && use_vd_q;
      last_stg_q[0] <= tok || is_last;
      id_stg_q[0]   <= id_q;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i]      <= vld_q[i-1];
        we_q[i]       <= we_q[i-1];
        last_stg_q[i] <= last_stg_q[i-1];
        id_stg_q[i]   <= id_stg_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      addr_stg_q[0] <= vd_addr;
      be_stg_q[0]   <= be_d;
      res_stg_q[0]  <= res_d;
      for (int i = 1; i < Latency; i++) begin
        addr_stg_q[i] <= addr_stg_q[i-1];
        be_stg_q[i]   <= be_stg_q[i-1];
        res_stg_q[i]  <= res_stg_q[i-1];
      end
    end
  end

  // ---- output stage ----
  assign vrf_we_o    = vld_q[Latency-1] && we_q[Latency-1];
  assign vrf_waddr_o = vrf_we_o ? addr_stg_q[Latency-1] : '0;
  assign vrf_wdata_o = vrf_we_o ? res_stg_q[Latency-1] : '0;
  assign vrf_wbe_o   = vrf_we_o ? be_stg_q[Latency-1] : '0;
  assign rsp_valid_o = vld_q[Latency-1] && last_stg_q[Latency-1] &&
                       (!we_q[Latency-1] || vrf_wvalid_i);
  assign rsp_id_o    = rsp_valid_o ? id_stg_q[Latency-1] : '0;

endmodule

// File: tb/tb_spatz_vfu_pipe.sv
// Directed bench for spatz_vfu_pipe: spec-level scoreboard of write-port events
// plus hand-computed literal results.
module tb_spatz_vfu_pipe;
  localparam int AW = 8;

  typedef struct {
    logic [2:0]  id;
    logic [2:0]  op;
    logic [1:0]  sew;
    logic [15:0] vl, vstart;
    logic [4:0]  vs1, vs2, vd;
    logic        use_vs1, use_vd;
    logic [31:0] rs1;
  } req_t;

  typedef struct {
    logic          we;
    logic          last;
    logic [7:0]    addr;
    logic [127:0]  data;
    logic [15:0]   be;
    logic [2:0]    id;
  } exp_t;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [2:0] req_id_i = '0, req_op_i = '0;
  logic [1:0] req_sew_i = '0;
  logic [15:0] req_vl_i = '0, req_vstart_i = '0;
  logic [4:0] req_vs1_i = '0, req_vs2_i = '0, req_vd_i = '0;
  logic req_use_vs1_i = 1'b0, req_use_vd_i = 1'b0;
  logic [31:0] req_rs1_i = '0;
  logic rsp_valid_o;
  logic [2:0] rsp_id_o;
  logic [2*AW-1:0] vrf_raddr_o;
  logic [1:0] vrf_re_o, vrf_rvalid_i;
  logic [255:0] vrf_rdata_i;
  logic [AW-1:0] vrf_waddr_o;
  logic [127:0] vrf_wdata_o;
  logic vrf_we_o;
  logic [15:0] vrf_wbe_o;
  logic vrf_wvalid_i = 1'b1;

  logic [127:0] mem [256];
  logic [127:0] wr_data [256];
  logic [15:0]  wr_be [256];
  int first_wr [8];
  int acc_cyc [8];
  int cyc = 0, checks = 0, errors = 0, rsp_cnt = 0;
  exp_t q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vrf_rvalid_i = vrf_re_o;
  assign vrf_rdata_i  = {mem[vrf_raddr_o[15:8]], mem[vrf_raddr_o[7:0]]};

  spatz_vfu_pipe dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_op_i(req_op_i), .req_sew_i(req_sew_i), .req_vl_i(req_vl_i),
    .req_vstart_i(req_vstart_i), .req_vs1_i(req_vs1_i), .req_vs2_i(req_vs2_i),
    .req_vd_i(req_vd_i), .req_use_vs1_i(req_use_vs1_i), .req_use_vd_i(req_use_vd_i),
    .req_rs1_i(req_rs1_i), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .vrf_raddr_o(vrf_raddr_o), .vrf_re_o(vrf_re_o), .vrf_rdata_i(vrf_rdata_i),
    .vrf_rvalid_i(vrf_rvalid_i), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
    .vrf_we_o(vrf_we_o), .vrf_wbe_o(vrf_wbe_o), .vrf_wvalid_i(vrf_wvalid_i)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask

  function automatic req_t mk(int id, int op, int sew, int vl, int vstart, int vs1, int vs2,
                              int vd, bit use_vs1, bit use_vd, logic [31:0] rs1);
    req_t r;
    r.id = 3'(id); r.op = 3'(op); r.sew = 2'(sew); r.vl = 16'(vl); r.vstart = 16'(vstart);
    r.vs1 = 5'(vs1); r.vs2 = 5'(vs2); r.vd = 5'(vd);
    r.use_vs1 = use_vs1; r.use_vd = use_vd; r.rs1 = rs1;
    return r;
  endfunction

  // Expected write-port events of one instruction, element by element.
  function automatic void model(input req_t r);
    int se, ew, epw, fw, lw, idx;
    exp_t e;
    logic [127:0] a, b;
    logic [63:0] m, x, y, z;
    se  = (r.sew == 2'd3) ? 2 : int'(r.sew);
    ew  = 8 << se;
    epw = 16 >> se;
    m   = (64'd1 << ew) - 64'd1;
    e   = '{default: '0};
    if (r.vl == 0 || r.vstart >= r.vl) begin
      e.last = 1'b1; e.id = r.id;
      q.push_back(e);
      return;
    end
    fw = int'(r.vstart) / epw;
    lw = (int'(r.vl) - 1) / epw;
    for (int w = fw; w <= lw; w++) begin
      e = '{default: '0};
      a = mem[8'(int'(r.vs2) * 8 + w)];
      b = mem[8'(int'(r.vs1) * 8 + w)];
      for (int k = 0; k < epw; k++) begin
        x = 64'((a >> (k*ew)) & 128'(m));
        y = r.use_vs1 ? 64'((b >> (k*ew)) & 128'(m)) : (64'(r.rs1) & m);
        case (r.op)
          3'd0: z = x + y;
          3'd1: z = x - y;
          3'd2: z = x & y;
          3'd3: z = x | y;
          3'd4: z = x ^ y;
          default: z = '0;
        endcase
        e.data = e.data | (128'(z & m) << (k*ew));
        idx = w*epw + k;
        if (idx >= int'(r.vstart) && idx < int'(r.vl))
          for (int bb = 0; bb < ew/8; bb++) e.be[k*(ew/8) + bb] = 1'b1;
      end
      e.we = r.use_vd; e.last = (w == lw); e.addr = 8'(int'(r.vd) * 8 + w); e.id = r.id;
      if (r.use_vd || e.last) q.push_back(e);
    end
  endfunction

  task automatic send(input req_t r, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    @(negedge clk);
    req_id_i = r.id; req_op_i = r.op; req_sew_i = r.sew; req_vl_i = r.vl;
    req_vstart_i = r.vstart; req_vs1_i = r.vs1; req_vs2_i = r.vs2; req_vd_i = r.vd;
    req_use_vs1_i = r.use_vs1; req_use_vd_i = r.use_vd; req_rs1_i = r.rs1;
    req_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready_o) begin
        acc_cyc[r.id] = cyc;
        model(r);
        acc = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL req_accept: id %0d not accepted within 50 cycles", r.id);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_left", 128'(q.size()), 128'd0);
  endtask

  task automatic clr_ids();
    for (int i = 0; i < 8; i++) begin first_wr[i] = -1; acc_cyc[i] = -1; end
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, {req_ready_o, rsp_valid_o, rsp_id_o, vrf_raddr_o, vrf_re_o, vrf_we_o,
             vrf_waddr_o, vrf_wbe_o, vrf_wdata_o}, '0);
  endtask

  // Scoreboard: every write or response leaving the pipe is checked here.
  logic stall_prev = 1'b0;
  logic [7:0] p_addr;
  logic [127:0] p_data;
  logic [15:0] p_be;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold", {vrf_we_o, vrf_waddr_o, vrf_wbe_o}, {1'b1, p_addr, p_be});
        chk("stall_data", vrf_wdata_o, p_data);
      end
      if (vrf_we_o && vrf_wvalid_i) begin
        if (q.size() == 0) fail("unexp_write");
        else begin
          e = q.pop_front();
          chk("wr_kind", e.we, 1);
          chk("wr_addr", vrf_waddr_o, e.addr);
          chk("wr_data", vrf_wdata_o, e.data);
          chk("wr_be", vrf_wbe_o, e.be);
          chk("wr_rsp", {rsp_valid_o, rsp_valid_o ? rsp_id_o : 3'd0},
              {e.last, e.last ? e.id : 3'd0});
          if (first_wr[e.id] < 0) first_wr[e.id] = cyc;
        end
        wr_data[vrf_waddr_o] = vrf_wdata_o;
        wr_be[vrf_waddr_o]   = vrf_wbe_o;
      end else if (rsp_valid_o) begin
        if (q.size() == 0) fail("unexp_rsp");
        else begin
          e = q.pop_front();
          chk("tok_kind", {e.we, e.last}, 2'b01);
          chk("tok_id", rsp_id_o, e.id);
        end
      end
      if (rsp_valid_o) rsp_cnt++;
      stall_prev = vrf_we_o && !vrf_wvalid_i;
      p_addr = vrf_waddr_o; p_data = vrf_wdata_o; p_be = vrf_wbe_o;
    end
  end

  initial begin
    int w1, w2, snap;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {32'(i*3 + 1), 32'(i ^ 32'hA5A5), 32'(i * 32'h01020304), ~32'(i)};
      wr_data[i] = '0; wr_be[i] = '0;
    end
    mem[16] = 128'h00000004_00000003_00000002_FFFFFFFF;
    mem[8]  = 128'h00000010_00000020_00000030_00000001;
    mem[32] = 128'h0F0E0D0C0B0A09080706050403020100;
    clr_ids();

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_outs_zero("reset_outs");
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("ready_after_reset", req_ready_o, 1);

    // Full-word 32-bit ADD
    send(mk(1, 0, 2, 8, 0, 1, 2, 3, 1, 1, 0), w1);
    idle();
    drain();
    chk("t1_data0", wr_data[24], 128'h00000014_00000023_00000032_00000000);
    chk("t1_be", {wr_be[24], wr_be[25]}, {16'hFFFF, 16'hFFFF});
    chk("t1_latency", 128'(first_wr[1] - acc_cyc[1]), 128'd3);

    // 8-bit SUB with scalar, partial first and last words
    send(mk(2, 1, 0, 21, 3, 0, 4, 5, 0, 1, 32'h01), w1);
    idle();
    drain();
    chk("t2_data0", wr_data[40], 128'h0E0D0C0B0A09080706050403020100FF);
    chk("t2_be0", wr_be[40], 16'hFFF8);
    chk("t2_be1", wr_be[41], 16'h001F);

    // Back-to-back single-word requests
    send(mk(3, 3, 2, 4, 0, 0, 2, 8, 0, 1, 32'h7), w1);
    send(mk(4, 4, 2, 4, 0, 1, 2, 9, 1, 1, 0), w2);
    idle();
    drain();
    chk("b2b_ready", {128'(w1), 128'(w2)}, '0);
    chk("b2b_spacing", 128'(first_wr[4] - first_wr[3]), 128'd1);

    // Write port stalled for 5 cycles mid-stream (16-bit AND, 8 words)
    send(mk(5, 2, 1, 60, 0, 1, 7, 10, 1, 1, 0), w1);
    idle();
    repeat (4) @(negedge clk);
    vrf_wvalid_i = 1'b0;
    repeat (5) @(negedge clk);
    vrf_wvalid_i = 1'b1;
    drain();
    chk("t4_last_be", wr_be[87], 16'h00FF);

    // Empty requests between normal ones
    clr_ids();
    send(mk(6, 0, 2, 4, 0, 1, 2, 12, 1, 1, 0), w1);
    send(mk(7, 0, 2, 0, 0, 1, 2, 11, 1, 1, 0), w1);
    send(mk(0, 1, 2, 4, 0, 0, 2, 13, 0, 1, 32'hFFFF0001), w1);
    send(mk(1, 0, 0, 8, 9, 1, 2, 11, 1, 1, 0), w1);
    idle();
    drain();
    chk("empty_no_write", wr_be[88], 16'h0000);

    // Reset during issue with two words in flight
    clr_ids();
    send(mk(2, 0, 2, 16, 0, 1, 2, 14, 1, 1, 0), w1);
    idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1 chk_outs_zero("mid_reset_outs");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    snap = rsp_cnt;
    repeat (4) @(negedge clk);
    chk("no_rsp_after_reset", 128'(rsp_cnt - snap), 128'd0);
    #1 chk("ready_after_mid_reset", req_ready_o, 1);
    send(mk(3, 0, 2, 8, 4, 1, 2, 15, 1, 1, 0), w1);
    send(mk(4, 0, 2, 16, 0, 1, 2, 6, 1, 0, 0), w1);
    idle();
    drain();
    chk("post_reset_be", wr_be[121], 16'hFFFF);
    chk("post_reset_latency", 128'(first_wr[3] - acc_cyc[3]), 128'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
